// File: rtl/mux4_rr_arbiter_if.sv
// Purpose : handshake/data bundle between four requesters, a shared 4:1 mux and its downstream sink.
// Latency : n/a (wires only).
// Backpr. : out_ready from the sink; requesters hold req/data until their ack bit pulses.
// Ports   : req[3:0], in1..in4 (requester side); out_ready (sink side);
//           gnt[3:0], sel[1:0], out_valid, out_data, ack[3:0] (driven by the arbiter).
//           modport slave = arbiter view, modport master = requester/sink view.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic             out_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       ack;

  modport slave (
    input  req, in1, in2, in3, in4, out_ready,
    output gnt, sel, out_valid, out_data, ack
  );

  modport master (
    output req, in1, in2, in3, in4, out_ready,
    input  gnt, sel, out_valid, out_data, ack
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Purpose : round-robin arbiter driving a 4:1 mux onto a valid/ready channel, MAX_BURST words per grant.
// Latency : req before edge N -> gnt/out_valid after edge N; one IDLE cycle after every release.
// Backpr. : out_ready=0 holds grant and burst count, no ack; dropping req[sel] releases the grant.
// Ports   : clk, rst (async, active-high); arb_bus (slave modport) carries req, in1..in4,
//           out_ready, gnt, sel, out_valid, out_data, ack.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  arb_bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Count value of the last transfer in a burst; MAX_BURST is limited to 1..15
  // so this fits the 4-bit counter and the counter never wraps.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t           state;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic [1:0]       last_q;
  logic [3:0]       burst_cnt;

  logic [1:0]       winner;
  logic             found;
  logic [1:0]       cand;
  logic [WIDTH-1:0] mux_dat;
  logic             out_vld;
  logic             xfer;

  // Circular search starting one past the last granted requester, so the
  // most recent owner has lowest priority in the next arbitration.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && arb_bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    mux_dat = '0;
    case (sel_q)
      2'd0:    mux_dat = arb_bus.in1;
      2'd1:    mux_dat = arb_bus.in2;
      2'd2:    mux_dat = arb_bus.in3;
      default: mux_dat = arb_bus.in4;
    endcase
  end

  // Channel outputs are combinational from the registered state so that an
  // async reset (state -> IDLE) drops out_valid and ack without a clock edge.
  assign out_vld = (state == GRANT) && arb_bus.req[sel_q];
  assign xfer    = out_vld && arb_bus.out_ready;

  assign arb_bus.out_valid = out_vld;
  assign arb_bus.out_data  = out_vld ? mux_dat : '0;
  assign arb_bus.ack       = xfer ? (4'b0001 << sel_q) : 4'b0000;
  assign arb_bus.gnt       = gnt_q;
  assign arb_bus.sel       = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      burst_cnt <= 4'd0;
      last_q    <= 2'd3;  // requester 0 wins the first arbitration
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt_q     <= 4'b0001 << winner;
            sel_q     <= winner;
            burst_cnt <= 4'd0;
          end
        end
        GRANT: begin
          if (!arb_bus.req[sel_q]) begin
            // Requester withdrew; any un-acked word is simply dropped.
            state  <= IDLE;
            gnt_q  <= 4'b0000;
            last_q <= sel_q;
          end else if (xfer) begin
            if (burst_cnt == BURST_LAST) begin
              state  <= IDLE;
              gnt_q  <= 4'b0000;
              last_q <= sel_q;
            end else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= 4'b0000;
        end
      endcase
    end
  end

endmodule
